// File: rtl/csa_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined carry-select
// adder/subtractor.
package csa_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // Pipeline stage in which carry-select block blk is evaluated.
  function automatic int stage_of_block(input int blk, input int stages, input int nblk);
    return (blk * stages) / nblk;
  endfunction

  // Highest-numbered block evaluated in a given stage; its carry-out is the
  // carry handed to the next stage.
  function automatic int last_block_of_stage(input int stage, input int stages, input int nblk);
    int last;
    last = 0;
    for (int i = 0; i < nblk; i++)
      if (stage_of_block(i, stages, nblk) == stage) last = i;
    return last;
  endfunction

  function automatic bit params_legal(input int width, input int block, input int stages);
    if (block < 1 || width < 1) return 1'b0;
    if (width % block != 0) return 1'b0;
    return (stages >= 1) && (stages <= width / block);
  endfunction

endpackage

// File: rtl/csa_addsub_pipe_if.sv
// Operand and result handshake bundle for csa_addsub_pipe.
interface csa_addsub_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, op_sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, op_sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/csa_block_n.sv
// Combinational N-bit carry-select slice: single ripple (SELECT=0) or two
// speculative ripples muxed by the incoming carry (SELECT=1).
module csa_block_n #(
  parameter int N      = 4,
  parameter bit SELECT = 1'b1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co,
  output logic         cmsb
);

  // Returns {carry into MSB, carry out, sum}.
  function automatic logic [N+1:0] ripple(input logic [N-1:0] x, input logic [N-1:0] y,
                                          input logic c0);
    logic [N:0]   c;
    logic [N-1:0] r;
    c    = '0;
    r    = '0;
    c[0] = c0;
    for (int j = 0; j < N; j++) begin
      r[j]   = x[j] ^ y[j] ^ c[j];
      c[j+1] = (x[j] & y[j]) | (c[j] & (x[j] ^ y[j]));
    end
    return {c[N-1], c[N], r};
  endfunction

  if (SELECT) begin : g_select
    logic [N+1:0] res0;
    logic [N+1:0] res1;
    assign res0 = ripple(a, b, 1'b0);
    assign res1 = ripple(a, b, 1'b1);
    assign {cmsb, co, s} = ci ? res1 : res0;
  end else begin : g_ripple
    assign {cmsb, co, s} = ripple(a, b, ci);
  end

endmodule

// File: rtl/csa_addsub_pipe.sv
// Pipelined carry-select adder/subtractor with elastic valid/ready flow; the
// NBLK blocks are spread over STAGES register cuts, the last cut drives outputs.
module csa_addsub_pipe
  import csa_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  csa_addsub_pipe_if.slave     ifc
);

  localparam int NBLK = WIDTH / BLOCK;

  if (!params_legal(WIDTH, BLOCK, STAGES)) begin : g_bad_params
    $fatal(1, "csa_addsub_pipe: WIDTH must be a multiple of BLOCK and 1 <= STAGES <= WIDTH/BLOCK");
  end

  typedef struct packed {
    logic             v;
    logic             c;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  logic [STAGES-1:0]            v;
  logic [STAGES-1:0]            adv;
  logic [STAGES-1:0]            in_v;
  logic [STAGES-1:0]            in_c;
  logic [STAGES-1:0][WIDTH-1:0] in_a;
  logic [STAGES-1:0][WIDTH-1:0] in_b;
  logic [STAGES-1:0][WIDTH-1:0] in_s;
  logic [WIDTH-1:0]             blk_sum;
  logic [NBLK-1:0]              blk_cmsb;

  // Advance chain, evaluated from the output back towards the input.
  always_comb begin
    logic go;
    adv = '0;
    go  = !v[STAGES-1] | ifc.out_ready;
    adv[STAGES-1] = go;
    for (int k = STAGES - 2; k >= 0; k--) begin
      go     = !v[k] | go;
      adv[k] = go;
    end
  end

  assign ifc.in_ready = adv[0];

  for (genvar i = 0; i < NBLK; i++) begin : g_blk
    localparam int STG   = stage_of_block(i, STAGES, NBLK);
    localparam bit FIRST = (i == 0) || (stage_of_block(i - 1, STAGES, NBLK) != STG);
    logic ci;
    logic co;

    if (FIRST) begin : g_cin_stage
      assign ci = in_c[STG];
    end else begin : g_cin_chain
      assign ci = g_blk[i-1].co;
    end

    csa_block_n #(
      .N      (BLOCK),
      .SELECT (i != 0)
    ) u_blk (
      .a    (in_a[STG][i*BLOCK +: BLOCK]),
      .b    (in_b[STG][i*BLOCK +: BLOCK]),
      .ci   (ci),
      .s    (blk_sum[i*BLOCK +: BLOCK]),
      .co   (co),
      .cmsb (blk_cmsb[i])
    );
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LAST = last_block_of_stage(k, STAGES, NBLK);
    stage_t r;
    stage_t nx;

    if (k == 0) begin : g_accept
      assign in_v[0] = ifc.in_valid;
      assign in_a[0] = ifc.a;
      assign in_b[0] = (ifc.op_sub == SUB) ? ~ifc.b : ifc.b;
      assign in_c[0] = (ifc.op_sub == SUB) ? 1'b1 : ifc.cin;
      assign in_s[0] = '0;
    end else begin : g_chain
      assign in_v[k] = g_stg[k-1].r.v;
      assign in_a[k] = g_stg[k-1].r.a;
      assign in_b[k] = g_stg[k-1].r.b;
      assign in_c[k] = g_stg[k-1].r.c;
      assign in_s[k] = g_stg[k-1].r.s;
    end

    // NOTE: every field gets a default before the per-block overrides, so no
    // latch can be inferred for bits this stage does not compute.
    always_comb begin
      nx.v = in_v[k];
      nx.c = g_blk[LAST].co;
      nx.a = in_a[k];
      nx.b = in_b[k];
      nx.s = in_s[k];
      for (int i = 0; i < NBLK; i++)
        if (stage_of_block(i, STAGES, NBLK) == k)
          nx.s[i*BLOCK +: BLOCK] = blk_sum[i*BLOCK +: BLOCK];
    end

    // NOTE: registers use non-blocking assignment so every stage samples the
    // previous stage's pre-edge value; datapath is reset too so outputs read 0.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r <= '0;
      else if (adv[k]) r <= nx;
    end

    assign v[k] = r.v;
  end

  logic ovf_q;
  logic zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv[STAGES-1]) begin
      ovf_q  <= blk_cmsb[NBLK-1] ^ g_blk[NBLK-1].co;
      zero_q <= (g_stg[STAGES-1].nx.s == '0);
    end
  end

  assign ifc.out_valid = g_stg[STAGES-1].r.v;
  assign ifc.sum       = g_stg[STAGES-1].r.s;
  assign ifc.cout      = g_stg[STAGES-1].r.c;
  assign ifc.ovf       = ovf_q;
  assign ifc.zero      = zero_q;

  // Operand bits already consumed by earlier stages are carried but never read.
  logic unused_dp;
  assign unused_dp = ^{in_a, in_b, blk_cmsb, g_stg[STAGES-1].r.a, g_stg[STAGES-1].r.b};

endmodule
